// File: rtl/ex_hazard_ctrl_pkg.sv
// rtl/ex_hazard_ctrl_pkg.sv - shared constants and types for EX hazard control
package ex_hazard_ctrl_pkg;

  // Default register index width.
  localparam int REG_INDEX_W = 5;

  // One-hot forwarding select: width and bit positions.
  localparam int SEL_W      = 4;
  localparam int SEL_ID2EX  = 0;
  localparam int SEL_EX2MEM = 1;
  localparam int SEL_MEM2WB = 2;
  localparam int SEL_LOP    = 3;

  // Stall cause codes, listed from highest to lowest priority after NONE.
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_LOAD_USE = 2'd1,
    CAUSE_BUSY     = 2'd2,
    CAUSE_LOP_FULL = 2'd3
  } stall_cause_e;

endpackage

// File: rtl/ex_fwd_sel.sv
// rtl/ex_fwd_sel.sv - one-hot forwarding select for a single EX source operand
module ex_fwd_sel
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_IDX_W = REG_INDEX_W
) (
  input  logic                 used,
  input  logic [REG_IDX_W-1:0] rs_index,
  input  logic                 ex2mem_valid,
  input  logic [REG_IDX_W-1:0] ex2mem_rd_index,
  input  logic                 mem2wb_valid,
  input  logic [REG_IDX_W-1:0] mem2wb_rd_index,
  input  logic                 lop_done,
  input  logic [REG_IDX_W-1:0] lop_rd_index,
  output logic [SEL_W-1:0]     sel
);

  // Youngest producer wins; r0 and unread operands always take the ID/EX value.
  always_comb begin
    sel = '0;
    if (!used || (rs_index == '0)) begin
      sel[SEL_ID2EX] = 1'b1;
    end else if (ex2mem_valid && (ex2mem_rd_index == rs_index)) begin
      sel[SEL_EX2MEM] = 1'b1;
    end else if (mem2wb_valid && (mem2wb_rd_index == rs_index)) begin
      sel[SEL_MEM2WB] = 1'b1;
    end else if (lop_done && (lop_rd_index == rs_index)) begin
      sel[SEL_LOP] = 1'b1;
    end else begin
      sel[SEL_ID2EX] = 1'b1;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX forwarding, long-op scoreboard, stall and watchdog (optional EX_HAZARD_PERF_EN)
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_IDX_W     = REG_INDEX_W,
  parameter int NUM_REGS      = 32,
  parameter int NUM_SRC       = 2,
  parameter int MAX_LOP       = 4,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           id2ex_valid_i,
  input  logic [NUM_SRC*REG_IDX_W-1:0]   id2ex_rs_index_i,
  input  logic [NUM_SRC-1:0]             id2ex_rs_used_i,
  input  logic [REG_IDX_W-1:0]           id2ex_rd_index_i,
  input  logic                           id2ex_long_i,
  input  logic                           ex_fire_i,
  input  logic                           ex2mem_valid_i,
  input  logic [REG_IDX_W-1:0]           ex2mem_rd_index_i,
  input  logic                           ex2mem_is_load_i,
  input  logic                           mem2wb_valid_i,
  input  logic [REG_IDX_W-1:0]           mem2wb_rd_index_i,
  input  logic                           lop_done_i,
  input  logic [REG_IDX_W-1:0]           lop_rd_index_i,
  output logic [NUM_SRC*SEL_W-1:0]       ex_src_sel_o,
  output logic                           ex_stall_o,
  output logic [1:0]                     ex_stall_cause_o,
  output logic [NUM_REGS-1:0]            sb_busy_o,
  output logic                           lop_full_o,
  output logic                           hazard_timeout_o
`ifdef EX_HAZARD_PERF_EN
  ,
  output logic [31:0]                    perf_loaduse_o,
  output logic [31:0]                    perf_busy_o,
  output logic [31:0]                    perf_full_o,
  output logic [31:0]                    perf_fwd_o
`endif
);

  localparam int CNT_W = $clog2(MAX_LOP + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOP);
  localparam int SC_W = ($clog2(STALL_TIMEOUT + 1) > 8) ? $clog2(STALL_TIMEOUT + 1) : 8;
  localparam logic [SC_W-1:0] SC_MAX    = '1;
  localparam logic [SC_W-1:0] SC_TIMEOUT = SC_W'(STALL_TIMEOUT);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [CNT_W-1:0]    lop_cnt;
  logic [SC_W-1:0]     stall_cnt;
  logic [SC_W-1:0]     stall_cnt_next;
  logic [NUM_SRC-1:0]  op_load_use;
  logic [NUM_SRC-1:0]  op_raw_busy;
  logic                waw_busy;
  logic                full_hit;
  logic                issue;
  logic                done;
  stall_cause_e        cause;

  // Per-operand forwarding select plus the operand's load-use and RAW hazard terms.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_IDX_W-1:0] rs;
    logic                 live;

    assign rs   = id2ex_rs_index_i[k*REG_IDX_W +: REG_IDX_W];
    assign live = id2ex_rs_used_i[k] && (rs != '0);

    assign op_load_use[k] = live && ex2mem_valid_i && ex2mem_is_load_i &&
                            (ex2mem_rd_index_i == rs);
    // A result arriving this cycle on the LOP path is forwarded, so no stall.
    assign op_raw_busy[k] = live && busy_q[rs] &&
                            !(lop_done_i && (lop_rd_index_i == rs));

    ex_fwd_sel #(
      .REG_IDX_W(REG_IDX_W)
    ) u_fwd_sel (
      .used            (id2ex_rs_used_i[k]),
      .rs_index        (rs),
      .ex2mem_valid    (ex2mem_valid_i),
      .ex2mem_rd_index (ex2mem_rd_index_i),
      .mem2wb_valid    (mem2wb_valid_i),
      .mem2wb_rd_index (mem2wb_rd_index_i),
      .lop_done        (lop_done_i),
      .lop_rd_index    (lop_rd_index_i),
      .sel             (ex_src_sel_o[k*SEL_W +: SEL_W])
    );
  end

  assign waw_busy = (id2ex_rd_index_i != '0) && busy_q[id2ex_rd_index_i] &&
                    !(lop_done_i && (lop_rd_index_i == id2ex_rd_index_i));
  assign full_hit = id2ex_long_i && (lop_cnt == MAX_CNT) && !lop_done_i;

  // Stall cause with priority load-use > busy > full, only for a valid EX instruction.
  always_comb begin
    cause = CAUSE_NONE;
    if (id2ex_valid_i) begin
      if (|op_load_use) begin
        cause = CAUSE_LOAD_USE;
      end else if ((|op_raw_busy) || waw_busy) begin
        cause = CAUSE_BUSY;
      end else if (full_hit) begin
        cause = CAUSE_LOP_FULL;
      end
    end
  end

  assign ex_stall_o       = (cause != CAUSE_NONE);
  assign ex_stall_cause_o = cause;
  assign sb_busy_o        = busy_q;
  assign lop_full_o       = (lop_cnt == MAX_CNT);

  assign issue = id2ex_valid_i && ex_fire_i && id2ex_long_i && !ex_stall_o;
  // A completion with nothing outstanding is bookkeeping noise and is dropped.
  assign done  = lop_done_i && (lop_cnt != '0);

  // Next busy vector: completions clear, issues set, set wins on the same index.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue && (id2ex_rd_index_i != '0)) begin
      set_mask[id2ex_rd_index_i] = 1'b1;
    end
    if (done) begin
      clr_mask[lop_rd_index_i] = 1'b1;
    end
    busy_next    = (busy_q & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  // Scoreboard state: busy bits and outstanding long-op count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      lop_cnt <= '0;
    end else begin
      busy_q <= busy_next;
      if (issue && !done) begin
        lop_cnt <= lop_cnt + CNT_W'(1);
      end else if (!issue && done) begin
        lop_cnt <= lop_cnt - CNT_W'(1);
      end
    end
  end

  // Saturating count of consecutive stall cycles.
  always_comb begin
    stall_cnt_next = '0;
    if (ex_stall_o) begin
      stall_cnt_next = (stall_cnt == SC_MAX) ? stall_cnt : stall_cnt + SC_W'(1);
    end
  end

  // Watchdog: flag sets once the stall run reaches the timeout and is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt        <= '0;
      hazard_timeout_o <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_next;
      if (ex_stall_o && (stall_cnt_next >= SC_TIMEOUT)) begin
        hazard_timeout_o <= 1'b1;
      end
    end
  end

  a_done_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    lop_done_i |-> (lop_cnt != '0));

`ifdef EX_HAZARD_PERF_EN
  logic [NUM_SRC-1:0] op_fwd;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_perf
    assign op_fwd[k] = !ex_src_sel_o[k*SEL_W + SEL_ID2EX];
  end

  // Per-cause stall cycle and forwarding-activity counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loaduse_o <= '0;
      perf_busy_o    <= '0;
      perf_full_o    <= '0;
      perf_fwd_o     <= '0;
    end else begin
      if ((cause == CAUSE_LOAD_USE) && (perf_loaduse_o != '1)) begin
        perf_loaduse_o <= perf_loaduse_o + 32'd1;
      end
      if ((cause == CAUSE_BUSY) && (perf_busy_o != '1)) begin
        perf_busy_o <= perf_busy_o + 32'd1;
      end
      if ((cause == CAUSE_LOP_FULL) && (perf_full_o != '1)) begin
        perf_full_o <= perf_full_o + 32'd1;
      end
      if ((|op_fwd) && (perf_fwd_o != '1)) begin
        perf_fwd_o <= perf_fwd_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Parametrised successor to the EX-stage forwarding logic. Generates per-operand one-hot forwarding selects for NUM_SRC source operands from the EX/MEM, MEM/WB and long-latency-unit (LOP) result paths. Adds sequential hazard control:
- per-register scoreboard for outstanding long-latency ops (div/mul);
- load-use, RAW-busy, WAW and LOP-full stall generation;
- a stall watchdog.
Sits beside the ID/EX register; its stall output freezes the IF/ID/EX front end.

Parameters:
REG_IDX_W, 5, register index width
NUM_REGS, 32, architectural registers (2**REG_IDX_W)
NUM_SRC, 2, source operands per EX instruction
MAX_LOP, 4, max outstanding long-latency ops
STALL_TIMEOUT, 255, consecutive stall cycles before watchdog fires

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
id2ex_valid_i  in  1  EX holds a valid instruction
id2ex_rs_index_i  in  NUM_SRC*REG_IDX_W  source indices, operand k at [k*REG_IDX_W +: REG_IDX_W]
id2ex_rs_used_i  in  NUM_SRC  operand k is read
id2ex_rd_index_i  in  REG_IDX_W  EX destination
id2ex_long_i  in  1  EX instruction is a long-latency op
ex_fire_i  in  1  EX instruction leaves EX this cycle (already qualified by !ex_stall_o upstream)
ex2mem_valid_i  in  1  EX/MEM valid
ex2mem_rd_index_i  in  REG_IDX_W  EX/MEM destination
ex2mem_is_load_i  in  1  EX/MEM holds a load
mem2wb_valid_i  in  1  MEM/WB valid
mem2wb_rd_index_i  in  REG_IDX_W  MEM/WB destination
lop_done_i  in  1  LOP result valid this cycle
lop_rd_index_i  in  REG_IDX_W  LOP result destination
ex_src_sel_o  out  NUM_SRC*4  one-hot per operand: bit0 id2ex, bit1 ex2mem, bit2 mem2wb, bit3 lop
ex_stall_o  out  1  hold EX and upstream
ex_stall_cause_o  out  2  0 none, 1 load-use, 2 RAW/WAW busy, 3 LOP full
sb_busy_o  out  NUM_REGS  scoreboard busy bits
lop_full_o  out  1  outstanding count == MAX_LOP
hazard_timeout_o  out  1  sticky watchdog flag

Behaviour:
Reset (async, rst_n=0):
- busy bits, outstanding count, stall counter and hazard_timeout_o all clear to 0.
- Combinational outputs follow inputs with zero state.
Forwarding, per operand k (combinational, zero latency):
- If !used or rs==0: select id2ex.
- Otherwise priority ex2mem (valid & rd match) > mem2wb (valid & rd match) > lop (lop_done & rd match) > id2ex.
- Exactly one bit is always set.
- A match on ex2mem with is_load selects ex2mem, but the stall below masks its use.
Stall, all terms gated by id2ex_valid_i; cause priority load-use > busy > full:
- Load-use: any used nonzero rs matches a valid load in EX/MEM.
- RAW busy: any used nonzero rs has busy=1 and is not (lop_done & lop_rd==rs).
- WAW busy: rd!=0 with busy[rd]=1 and not cleared this cycle.
- LOP full: id2ex_long & count==MAX_LOP & !lop_done_i.
Scoreboard, registered:
- Issue = id2ex_valid & ex_fire_i & id2ex_long & !ex_stall_o.
- Issue sets busy[rd] when rd!=0. Count increments on every issue, including rd==0.
- lop_done_i clears busy[lop_rd] and decrements count if count>0.
- Issue and done in the same cycle: count unchanged. Same index: set wins.
- Done with count==0 is ignored; assertion error.
- busy[0] is always 0.
Watchdog:
- 8-bit-min saturating counter increments while ex_stall_o=1 and clears otherwise.
- At STALL_TIMEOUT, hazard_timeout_o sets and holds until reset.

Optional Feature:
EX_HAZARD_PERF_EN:
- When defined, adds 32-bit saturating counters perf_loaduse_o, perf_busy_o, perf_full_o and perf_fwd_o. The first three count stall cycles by cause; perf_fwd_o counts cycles in which any operand selects a non-id2ex path.
- All counters reset to 0.
- When undefined, these ports and counters do not exist.

Decomposition:
- Shared package/defines: REG_INDEX width, stall-cause codes, select-bit positions (SEL_ID2EX..SEL_LOP).
- One sub-module, ex_fwd_sel: per-operand priority select, instantiated NUM_SRC times via generate.
- Scoreboard, stall and watchdog stay in the top module.

Test Plan:
- Back-to-back ALU: ex2mem rd=5 and mem2wb rd=5, rs1=5 → sel rs1=4'b0010, no stall; rs2=0 → 4'b0001.
- Load-use: ex2mem load rd=7, rs2=7 used → stall=1, cause=1 for one cycle; next cycle load sits in mem2wb → sel=4'b0100, stall=0.
- Div issue rd=9, then rs1=9 → stall, cause=2, until lop_done rd=9. In the done cycle: sel=4'b1000, stall=0, busy[9] clears next cycle.
- Issue MAX_LOP=4 long ops rd=1..4 → lop_full_o=1; fifth long op stalls with cause=3. lop_done in the same cycle releases the stall; count stays 4.
- Assert rst_n low mid-stall with busy[3]=1 → busy, count and timeout are 0 immediately (async), without waiting for a clock edge.
- Hold a RAW stall for 255 cycles → hazard_timeout_o=1 and remains 1 after the stall clears.
